// File: rtl/reg_file_writeback_pkg.sv
// Shared types for the OTTER writeback stage: result select, load funct3 codes
// and the FIFO entry captured from MEM/WB.
package otter_wb_pkg;
  typedef enum logic [1:0] {
    SEL_ALU = 2'd0,
    SEL_MEM = 2'd1,
    SEL_PC4 = 2'd2,
    SEL_CSR = 2'd3
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] FIFO_FULL = 2'd2;

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  rd;
    wb_sel_t     sel;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [31:0] csr;
  } wb_entry_t;
endpackage

// File: rtl/reg_file_writeback_if.sv
// MEM/WB -> writeback handshake plus the register-file write port and status.
interface reg_file_writeback_if;
  logic        WB_IN_VALID;
  logic        WB_IN_READY;
  logic        WB_REGWRITE;
  logic [4:0]  WB_RD;
  logic [1:0]  WB_SEL;
  logic [2:0]  WB_FUNCT3;
  logic [1:0]  WB_ADDR_LO;
  logic [31:0] WB_ALU;
  logic [31:0] WB_MEM;
  logic [31:0] WB_PC;
  logic [31:0] WB_CSR;
  logic        WB_HOLD;
  logic [4:0]  RF_WA;
  logic [31:0] RF_WD;
  logic        RF_EN;
  logic        WB_PENDING;

  modport master (
    output WB_IN_VALID, WB_REGWRITE, WB_RD, WB_SEL, WB_FUNCT3, WB_ADDR_LO,
           WB_ALU, WB_MEM, WB_PC, WB_CSR, WB_HOLD,
    input  WB_IN_READY, RF_WA, RF_WD, RF_EN, WB_PENDING
  );

  modport slave (
    input  WB_IN_VALID, WB_REGWRITE, WB_RD, WB_SEL, WB_FUNCT3, WB_ADDR_LO,
           WB_ALU, WB_MEM, WB_PC, WB_CSR, WB_HOLD,
    output WB_IN_READY, RF_WA, RF_WD, RF_EN, WB_PENDING
  );
endinterface

// File: rtl/reg_file_writeback_load_extend.sv
// Load formatter: picks byte/halfword/word out of the aligned memory word
// and sign- or zero-extends it according to funct3.
module load_extend
  import otter_wb_pkg::*;
(
  input  logic [31:0] i_mem,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_mem[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_mem[7:0];
      2'd1: w_byte = i_mem[15:8];
      2'd2: w_byte = i_mem[23:16];
      2'd3: w_byte = i_mem[31:24];
      default: w_byte = i_mem[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_mem[31:16] : i_mem[15:0];
  end

  // Unknown funct3 codes fall back to a full-word load.
  always_comb begin
    o_data = i_mem;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_mem;
    endcase
  end
endmodule

// File: rtl/reg_file_writeback.sv
// Writeback stage: 2-entry FIFO from MEM/WB, result select/format on the head,
// and one registered register-file write per cycle.
module reg_file_writeback
  import otter_wb_pkg::*;
(
  input  logic                  WB_CLK,
  input  logic                  WB_RST_N,
  reg_file_writeback_if.slave   wb
);
  wb_entry_t   r_fifo [2];
  logic        r_head;
  logic        r_tail;
  logic [1:0]  r_count;
  logic        r_en;
  logic [4:0]  r_wa;
  logic [31:0] r_wd;

  wb_entry_t   w_in;
  wb_entry_t   w_head;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_load;
  logic [31:0] w_result;

  always_comb begin
    w_in.regwrite = wb.WB_REGWRITE;
    w_in.rd       = wb.WB_RD;
    w_in.sel      = wb_sel_t'(wb.WB_SEL);
    w_in.funct3   = wb.WB_FUNCT3;
    w_in.addr_lo  = wb.WB_ADDR_LO;
    w_in.alu      = wb.WB_ALU;
    w_in.mem      = wb.WB_MEM;
    w_in.pc       = wb.WB_PC;
    w_in.csr      = wb.WB_CSR;
  end

  assign wb.WB_IN_READY = (r_count != FIFO_FULL);
  assign w_push         = wb.WB_IN_VALID && wb.WB_IN_READY;
  assign w_pop          = !wb.WB_HOLD && (r_count != 2'd0);
  assign w_head         = r_fifo[r_head];

  // Entry storage carries no control meaning, so it needs no reset.
  always_ff @(posedge WB_CLK) begin
    if (w_push) r_fifo[r_tail] <= w_in;
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  load_extend u_load_extend (
    .i_mem     (w_head.mem),
    .i_addr_lo (w_head.addr_lo),
    .i_funct3  (w_head.funct3),
    .o_data    (w_load)
  );

  always_comb begin
    w_result = w_head.alu;
    case (w_head.sel)
      SEL_ALU: w_result = w_head.alu;
      SEL_MEM: w_result = w_load;
      SEL_PC4: w_result = w_head.pc + 32'd4;
      SEL_CSR: w_result = w_head.csr;
      default: w_result = w_head.alu;
    endcase
  end

  // x0 entries still pop and update WA/WD; only the enable is suppressed.
  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      r_en <= 1'b0;
      r_wa <= 5'd0;
      r_wd <= 32'd0;
    end else begin
      r_en <= w_pop && w_head.regwrite && (w_head.rd != 5'd0);
      if (w_pop) begin
        r_wa <= w_head.rd;
        r_wd <= w_result;
      end
    end
  end

  assign wb.RF_EN      = r_en;
  assign wb.RF_WA      = r_wa;
  assign wb.RF_WD      = r_wd;
  assign wb.WB_PENDING = (r_count != 2'd0) | r_en;
endmodule
